// File: rtl/timer_ctrl_if.sv
// Counter-side connection of the timer controller: the hh:mm:ss counter
// reports wrap-around on ovf and receives tick/clear/edit commands.
interface timer_ctrl_if;
  logic       ovf;
  logic       tick_en;
  logic       clr;
  logic [1:0] set_sel;
  logic       inc_pulse;
  logic       blink;

  modport master (
    input  ovf,
    output tick_en, clr, set_sel, inc_pulse, blink
  );

  modport slave (
    output ovf,
    input  tick_en, clr, set_sel, inc_pulse, blink
  );
endinterface

// File: rtl/timer_ctrl.sv
// Stopwatch/clock-set controller: debounces three active-low keys, runs the
// IDLE/RUN/PAUSE/SET_MIN/SET_HOUR state machine, generates the one-second
// count enable and the blink enable for the field being edited.
module timer_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_start,
  input  logic         key_mode,
  input  logic         key_inc,
  output logic [2:0]   state,
  timer_ctrl_if.master cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    RUN      = 3'b001,
    PAUSE    = 3'b010,
    SET_MIN  = 3'b011,
    SET_HOUR = 3'b100
  } state_t;

  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DW   = $clog2(DEB_CYCLES + 1);

  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(HALF - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  // key index 0 = start, 1 = mode, 2 = inc
  logic [2:0]    key_raw;
  logic [2:0]    sync1, sync2;
  logic [2:0]    deb;
  logic [2:0]    press;
  logic [DW-1:0] dcnt [3];

  logic ev_start, ev_mode, ev_inc;

  state_t        state_q, state_d;
  logic          clr_d, inc_d;
  logic [1:0]    sel_d;
  logic          in_set_d;

  logic          clr_q, inc_q, tick_q, blink_q;
  logic [1:0]    sel_q;
  logic [PW-1:0] pre;
  logic [BW-1:0] bcnt;

  assign key_raw = {key_inc, key_mode, key_start};

  // two-flop synchronizers; reset to the released level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // debounce: accept a new level after DEB_CYCLES consecutive mismatches, flag falling edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb   <= '1;
      press <= '0;
      for (int unsigned i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != deb[i]) begin
          if (dcnt[i] == DEB_MAX) begin
            deb[i]   <= sync2[i];
            dcnt[i]  <= '0;
            press[i] <= ~sync2[i];
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  // a start press swallows a coincident mode press
  assign ev_start = press[0];
  assign ev_mode  = press[1] & ~press[0];
  assign ev_inc   = press[2];

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state, clear and increment decisions
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    inc_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_start)     state_d = RUN;
        else if (ev_mode) state_d = SET_MIN;
      end
      RUN: begin
        if (cnt.ovf) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (ev_start) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (ev_start) begin
          state_d = RUN;
        end else if (ev_mode) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      SET_MIN: begin
        if (ev_mode)     state_d = SET_HOUR;
        else if (ev_inc) inc_d   = 1'b1;
      end
      SET_HOUR: begin
        if (ev_mode)     state_d = IDLE;
        else if (ev_inc) inc_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // field selection derived from the upcoming state
  always_comb begin
    sel_d    = 2'b00;
    in_set_d = 1'b0;
    case (state_d)
      SET_MIN:  begin sel_d = 2'b01; in_set_d = 1'b1; end
      SET_HOUR: begin sel_d = 2'b10; in_set_d = 1'b1; end
      default:  begin sel_d = 2'b00; in_set_d = 1'b0; end
    endcase
  end

  // registered command outputs; clr held high through reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_q <= 1'b1;
      inc_q <= 1'b0;
      sel_q <= 2'b00;
    end else begin
      clr_q <= clr_d;
      inc_q <= inc_d;
      sel_q <= sel_d;
    end
  end

  // one-second prescaler: counts in RUN, holds in PAUSE, cleared elsewhere
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre    <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (pre == PRE_MAX) begin
            // a second completing on the way out of RUN is kept pending
            if (state_d == RUN) begin
              pre    <= '0;
              tick_q <= 1'b1;
            end
          end else begin
            pre <= pre + PW'(1);
          end
        end
        PAUSE:   pre <= pre;
        default: pre <= '0;
      endcase
    end
  end

  // blink: restart visible on entering a SET state, toggle every half second
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= 1'b0;
      bcnt    <= '0;
    end else if (!in_set_d) begin
      blink_q <= 1'b0;
      bcnt    <= '0;
    end else if (state_d != state_q) begin
      blink_q <= 1'b1;
      bcnt    <= '0;
    end else if (bcnt == BLK_MAX) begin
      blink_q <= ~blink_q;
      bcnt    <= '0;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  assign state         = state_q;
  assign cnt.tick_en   = tick_q;
  assign cnt.clr       = clr_q;
  assign cnt.set_sel   = sel_q;
  assign cnt.inc_pulse = inc_q;
  assign cnt.blink     = blink_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with CLK_HZ=20, DEB_CYCLES=4: a behavioural model
// predicts every output each cycle, and directed scenarios pin latencies and
// tick spacing with hand-computed literals.
module tb_timer_ctrl;
  localparam int HZ   = 20;
  localparam int DEB  = 4;
  localparam int HALF = HZ / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_start, key_mode, key_inc;
  logic [2:0] state;

  timer_ctrl_if bus ();

  timer_ctrl #(.CLK_HZ(HZ), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .state     (state),
    .cnt       (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_inc   = 0;

  // model state: states use the documented codes, frac = cycles of the
  // current second already spent in RUN, age = cycles since entering a SET state
  int m_st, m_sel, m_frac, m_age;
  bit m_tick, m_clr, m_inc, m_blink;
  bit m_d1 [3];
  bit m_d2 [3];
  bit m_acc [3];
  bit m_ev [3];
  int m_run [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_sel = 0; m_frac = 0; m_age = 0;
    m_tick = 0; m_clr = 1; m_inc = 0; m_blink = 0;
    for (int k = 0; k < 3; k++) begin
      m_d1[k] = 1; m_d2[k] = 1; m_acc[k] = 1; m_ev[k] = 0; m_run[k] = 0;
    end
  endtask

  task automatic model_step();
    bit raw [3];
    bit nev [3];
    bit es, em, ei, clr_n, inc_n;
    int nst;
    raw[0] = key_start; raw[1] = key_mode; raw[2] = key_inc;
    es = m_ev[0];
    em = m_ev[1] && !m_ev[0];
    ei = m_ev[2];
    for (int k = 0; k < 3; k++) begin
      nev[k] = 0;
      if (m_d2[k] != m_acc[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_acc[k] = m_d2[k];
          m_run[k] = 0;
          nev[k]   = !m_acc[k];
        end
      end else begin
        m_run[k] = 0;
      end
      m_d2[k] = m_d1[k];
      m_d1[k] = raw[k];
      m_ev[k] = nev[k];
    end
    nst = m_st; clr_n = 0; inc_n = 0;
    case (m_st)
      0: if (es) nst = 1; else if (em) nst = 3;
      1: if (bus.ovf) begin nst = 0; clr_n = 1; end else if (es) nst = 2;
      2: if (es) nst = 1; else if (em) begin nst = 0; clr_n = 1; end
      3: if (em) nst = 4; else if (ei) inc_n = 1;
      4: if (em) nst = 0; else if (ei) inc_n = 1;
      default: nst = 0;
    endcase
    m_tick = 0;
    if (m_st == 1) begin
      if (m_frac == HZ - 1) begin
        if (nst == 1) begin m_tick = 1; m_frac = 0; end
      end else begin
        m_frac++;
      end
    end else if (m_st != 2) begin
      m_frac = 0;
    end
    if (nst == 3 || nst == 4) begin
      if (nst != m_st) m_age = 0; else m_age++;
      m_blink = ((m_age / HALF) % 2) == 0;
    end else begin
      m_age = 0;
      m_blink = 0;
    end
    m_sel = (nst == 3) ? 1 : (nst == 4) ? 2 : 0;
    m_clr = clr_n;
    m_inc = inc_n;
    m_st  = nst;
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0:       key_start = v;
      1:       key_mode  = v;
      default: key_inc   = v;
    endcase
  endtask

  task automatic press(input int which);
    @(negedge clk); drive(which, 1'b0);
    repeat (8) @(negedge clk);
    drive(which, 1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] want, input int bound, input string name, output int at);
    bit hit;
    hit = 0; at = -1;
    for (int n = 0; n < bound && !hit; n++) begin
      @(negedge clk);
      if (state === want) begin hit = 1; at = cyc; end
    end
    check(name, {31'b0, hit}, 32'd1);
  endtask

  task automatic wait_tick(input int bound, input string name, output int at);
    bit hit;
    hit = 0; at = -1;
    for (int n = 0; n < bound && !hit; n++) begin
      @(negedge clk);
      if (bus.tick_en === 1'b1) begin hit = 1; at = cyc; end
    end
    check(name, {31'b0, hit}, 32'd1);
  endtask

  initial begin : main
    int t0, t1, t2, tp, tr, tt, c0, base;
    bit moved;
    rst = 1'b0;
    key_start = 1'b1; key_mode = 1'b1; key_inc = 1'b1;
    bus.ovf = 1'b0;

    fork
      forever begin
        @(posedge clk or negedge rst);
        if (!rst) model_reset();
        else      model_step();
      end
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (bus.inc_pulse === 1'b1) n_inc++;
      end
      begin : cmp
        logic [8:0] e, a;
        forever begin
          @(negedge clk);
          e = {3'(m_st), m_tick, m_clr, 2'(m_sel), m_inc, m_blink};
          a = {state, bus.tick_en, bus.clr, bus.set_sel, bus.inc_pulse, bus.blink};
          check("cycle_model", {23'b0, a}, {23'b0, e});
        end
      end
    join_none

    // reset values
    repeat (2) @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_clr", bus.clr, 1'b1);
    check("rst_outs", {bus.tick_en, bus.set_sel, bus.inc_pulse, bus.blink}, 5'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("clr_release", bus.clr, 1'b0);

    // a 3-cycle bounce is rejected
    @(negedge clk); key_start = 1'b0;
    repeat (3) @(negedge clk);
    key_start = 1'b1;
    moved = 0;
    repeat (15) begin
      @(negedge clk);
      if (state !== 3'd0 || bus.tick_en !== 1'b0) moved = 1;
    end
    check("bounce_ignored", {31'b0, moved}, 32'd0);

    // start held 10 cycles: one press, RUN, ticks every 20 cycles
    @(negedge clk); key_start = 1'b0; c0 = cyc;
    wait_state(3'd1, 30, "enter_run", t0);
    check("press_latency", t0 - c0, 32'd7);
    repeat (3) @(negedge clk);
    key_start = 1'b1;
    wait_tick(40, "first_tick_seen", t1);
    check("first_tick_gap", t1 - t0, 32'd20);
    wait_tick(40, "second_tick_seen", t2);
    check("tick_period", t2 - t1, 32'd20);
    check("still_run", state, 3'd1);

    // pause with prescaler at 7, resume after 50 cycles: 12 cycles to next tick
    @(negedge clk); key_start = 1'b0;
    wait_state(3'd2, 20, "enter_pause", tp);
    check("pause_at_pre7", tp - t2, 32'd8);
    repeat (4) @(negedge clk);
    key_start = 1'b1;
    repeat (50) @(negedge clk);
    key_start = 1'b0;
    wait_state(3'd1, 20, "resume_run", tr);
    repeat (4) @(negedge clk);
    key_start = 1'b1;
    wait_tick(40, "resume_tick_seen", tt);
    check("resume_tick_gap", tt - tr, 32'd12);

    // ovf coinciding with a start press: ovf wins, no PAUSE
    @(negedge clk); key_start = 1'b0;
    repeat (6) @(negedge clk);
    bus.ovf = 1'b1;
    @(negedge clk); bus.ovf = 1'b0;
    check("ovf_wins_state", state, 3'd0);
    check("ovf_clr_pulse", bus.clr, 1'b1);
    @(negedge clk);
    check("ovf_clr_one_cycle", bus.clr, 1'b0);
    key_start = 1'b1;
    repeat (12) @(negedge clk);
    check("ovf_idle_hold", state, 3'd0);

    // set sequence: mode, inc, inc, mode, inc, mode
    base = n_inc;
    press(1);
    check("set_min_state", state, 3'd3);
    check("set_min_sel", bus.set_sel, 2'b01);
    press(2);
    press(2);
    press(1);
    check("set_hour_state", state, 3'd4);
    check("set_hour_sel", bus.set_sel, 2'b10);
    press(2);
    press(1);
    check("set_exit_state", state, 3'd0);
    check("set_exit_sel", bus.set_sel, 2'b00);
    check("inc_count", n_inc - base, 32'd3);

    // simultaneous start+mode from IDLE: start wins
    @(negedge clk); key_start = 1'b0; key_mode = 1'b0;
    repeat (8) @(negedge clk);
    key_start = 1'b1; key_mode = 1'b1;
    repeat (10) @(negedge clk);
    check("start_priority", state, 3'd1);

    // PAUSE then mode: back to IDLE with clr
    press(0);
    check("pause_again", state, 3'd2);
    @(negedge clk); key_mode = 1'b0;
    wait_state(3'd0, 20, "pause_to_idle", tp);
    check("pause_mode_clr", bus.clr, 1'b1);
    repeat (6) @(negedge clk);
    key_mode = 1'b1;
    repeat (10) @(negedge clk);

    // reset in SET_HOUR while blinking
    press(1);
    @(negedge clk); key_mode = 1'b0;
    wait_state(3'd4, 20, "reach_set_hour", tp);
    check("set_hour_blink", bus.blink, 1'b1);
    key_mode = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", state, 3'd0);
    check("async_rst_outs", {bus.clr, bus.blink, bus.set_sel}, 4'b1000);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst2_clr_release", bus.clr, 1'b0);
    base = n_inc;
    repeat (20) @(negedge clk);
    check("no_event_after_rst", {26'b0, state, bus.set_sel, bus.inc_pulse}, 32'd0);
    check("no_inc_after_rst", n_inc - base, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clock cycles per second tick.
REQ-002 Parameter DEB_CYCLES, default 1000000, cycles a key level must stay stable before acceptance (20 ms at 50 MHz).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 key_start  in  1  start/pause button, active-low, asynchronous to clk.
REQ-006 key_mode  in  1  mode button, active-low, asynchronous to clk.
REQ-007 key_inc  in  1  increment button, active-low, asynchronous to clk.
REQ-008 ovf  in  1  one-cycle pulse from the hh:mm:ss counter when it wraps past 99:59:59.
REQ-009 tick_en  out  1  one-cycle count-enable pulse for the counter, one per second in RUN.
REQ-010 clr  out  1  one-cycle synchronous clear pulse for the counter.
REQ-011 set_sel  out  2  field being edited: 00 none, 01 minutes, 10 hours.
REQ-012 inc_pulse  out  1  one-cycle pulse incrementing the field selected by set_sel.
REQ-013 state  out  3  current FSM state code.
REQ-014 blink  out  1  display blink enable for the edited field.

Function
REQ-015 Each key SHALL pass through a two-flop synchronizer before any other use.
REQ-016 Debounce: the debounced level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-017 A press event SHALL be a single-cycle internal pulse on a debounced high-to-low transition; holding a key SHALL produce no further events.
REQ-018 FSM states and codes: IDLE=000, RUN=001, PAUSE=010, SET_MIN=011, SET_HOUR=100; state output SHALL equal the current state register.
REQ-019 IDLE: start press -> RUN; mode press -> SET_MIN.
REQ-020 RUN: start press -> PAUSE; ovf -> IDLE with clr pulsed.
REQ-021 PAUSE: start press -> RUN; mode press -> IDLE with clr pulsed.
REQ-022 SET_MIN: mode press -> SET_HOUR; inc press -> inc_pulse. SET_HOUR: mode press -> IDLE; inc press -> inc_pulse.
REQ-023 Events not listed for a state SHALL be ignored.
REQ-024 Simultaneous start and mode presses in one cycle: start press SHALL take priority and mode press SHALL be discarded.
REQ-025 ovf in the same cycle as a start press in RUN: ovf SHALL win (-> IDLE, clr pulsed).
REQ-026 All outputs SHALL be registered; an event pulse in cycle N SHALL update state/clr/inc_pulse at the clock edge ending cycle N.
REQ-027 Prescaler counts 0..CLK_HZ-1 only in RUN; tick_en SHALL pulse in the cycle after it reaches CLK_HZ-1, and it then wraps to 0.
REQ-028 Prescaler SHALL hold its value in PAUSE (fraction of a second preserved) and be cleared to 0 in IDLE, SET_MIN and SET_HOUR.
REQ-029 tick_en SHALL never be asserted outside RUN, including the cycle of leaving RUN.
REQ-030 set_sel SHALL be 01 in SET_MIN, 10 in SET_HOUR, 00 otherwise.
REQ-031 blink SHALL toggle every CLK_HZ/2 cycles while in a SET state, starting at 1 on entry, and be 0 in all other states.

Reset
REQ-032 On rst low: state=IDLE, tick_en=0, clr=1, set_sel=00, inc_pulse=0, blink=0, prescaler=0, debounced levels=1 (released), debounce counters=0.
REQ-033 clr SHALL deassert in the first cycle after rst is released; reset asserted mid-RUN or mid-SET SHALL return to IDLE immediately, asynchronously.
REQ-034 No press event SHALL be generated by the reset release itself.

Verification (CLK_HZ=20, DEB_CYCLES=4)
REQ-035 Hold key_start low 10 cycles from IDLE -> one press event, state 001, tick_en pulse every 20 cycles, first one 20 cycles after RUN entry.
REQ-036 key_start low 3 cycles then high (bounce) -> no state change, tick_en stays 0.
REQ-037 RUN, press start at prescaler=7, wait 50 cycles, press start -> PAUSE then RUN, next tick_en 12 cycles after RUN re-entry.
REQ-038 IDLE, mode, inc, inc, mode, inc, mode -> states 011,100,000; inc_pulse exactly 3 times; set_sel 01 then 10 then 00.
REQ-039 RUN with ovf and start press same cycle -> state 000, clr one-cycle pulse, no PAUSE.
REQ-040 Assert rst in SET_HOUR with blink=1 -> state 000, blink 0, set_sel 00, clr 1 immediately; after release clr 0, no events.
